// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Operand capture (A from SPI strobe, B from selector buttons),
//                edge-triggered ALU execute (MUL/SUB/AND/XOR, iterative
//                shift-add multiplier), result/flag hold and result-driven PWM.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int W  = 4,   // operand/result width, at least 2
    parameter int NB = 4    // operand-B selector buttons, clog2(NB) <= W
) (
    input  logic           FPGA_clk,
    input  logic           FPGA_reset,
    input  logic [W-1:0]   spi_data,
    input  logic           spi_valid,
    input  logic [NB-1:0]  opb_btn_n,
    input  logic [3:0]     op_btn,
    output logic [W-1:0]   op_a,
    output logic [W-1:0]   op_b,
    output logic [W-1:0]   result,
    output logic [3:0]     flags,
    output logic           busy,
    output logic           done,
    output logic           pwm_out
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_MUL  = 2'd2;

    localparam logic [1:0] OP_MUL  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_AND  = 2'd2;
    localparam logic [1:0] OP_XOR  = 2'd3;

    // Multiplier step counter width; W >= 2 keeps this at least 1 bit.
    localparam int CW = $clog2(W);

    localparam logic [CW-1:0] MUL_LAST_STEP = CW'(W - 1);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [1:0]      state;
    logic [3:0]      btn_prev;
    logic [3:0]      btn_rise;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    a_next;
    logic            b_pressed;
    logic [W-1:0]    b_idx;

    logic            start_valid;
    logic [1:0]      start_op;

    logic [1:0]      exec_op;
    logic [W-1:0]    exec_a;
    logic [W-1:0]    exec_b;

    logic [2*W-1:0]  mul_acc;
    logic [2*W-1:0]  mul_mcand;
    logic [W-1:0]    mul_mplier;
    logic [CW-1:0]   mul_cnt;
    logic [2*W-1:0]  mul_acc_next;
    logic            mul_last;

    logic [W:0]      sub_diff;
    logic [W-1:0]    alu_r;
    logic            alu_c;
    logic            alu_v;

    logic            fin_valid;
    logic [W-1:0]    fin_r;
    logic            fin_c;
    logic            fin_v;

    logic [W-1:0]    pwm_cnt;

    // ------------------------------------------------------------------
    // Operand and button-edge front end
    // ------------------------------------------------------------------
    assign btn_rise = op_btn & ~btn_prev;

    // A value as seen by a start on this cycle: a coincident SPI strobe wins.
    assign a_next = spi_valid ? spi_data : a_reg;

    // Lowest-indexed pressed (low) selector button gives the B index.
    always_comb begin
        b_pressed = 1'b0;
        b_idx     = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (!opb_btn_n[i]) begin
                b_pressed = 1'b1;
                b_idx     = W'(i);
            end
        end
    end

    // Capture operands and the previous button sample; the all-ones reset
    // value keeps a button held through reset release from firing.
    always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
        if (FPGA_reset) begin
            btn_prev <= 4'hF;
            a_reg    <= '0;
            b_reg    <= '0;
        end else begin
            btn_prev <= op_btn;
            if (spi_valid) begin
                a_reg <= spi_data;
            end
            if (b_pressed) begin
                b_reg <= b_idx;
            end
        end
    end

    assign op_a = a_reg;
    assign op_b = b_reg;

    // ------------------------------------------------------------------
    // Start decode: only from IDLE, fixed priority MUL > SUB > AND > XOR
    // ------------------------------------------------------------------
    // Pick the single op to launch from this cycle's rising edges.
    always_comb begin
        start_valid = (state == ST_IDLE) && (|btn_rise);
        if (btn_rise[0]) begin
            start_op = OP_MUL;
        end else if (btn_rise[1]) begin
            start_op = OP_SUB;
        end else if (btn_rise[2]) begin
            start_op = OP_AND;
        end else begin
            start_op = OP_XOR;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and operand snapshot
    // ------------------------------------------------------------------
    // Sequence IDLE -> EXEC (one cycle) or IDLE -> MUL (W cycles) -> IDLE.
    always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
        if (FPGA_reset) begin
            state   <= ST_IDLE;
            exec_op <= OP_MUL;
            exec_a  <= '0;
            exec_b  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        exec_op <= start_op;
                        exec_a  <= a_next;
                        exec_b  <= b_reg;
                        state   <= (start_op == OP_MUL) ? ST_MUL : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state <= ST_IDLE;
                end
                ST_MUL: begin
                    if (mul_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

    // ------------------------------------------------------------------
    // Shift-add multiplier: one multiplier bit per cycle, LSB first
    // ------------------------------------------------------------------
    assign mul_acc_next = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
    assign mul_last     = (state == ST_MUL) && (mul_cnt == MUL_LAST_STEP);

    // Load on a MUL start, then accumulate and shift once per MUL cycle.
    always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
        if (FPGA_reset) begin
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_cnt    <= '0;
        end else if (start_valid && (start_op == OP_MUL)) begin
            mul_acc    <= '0;
            mul_mcand  <= {{W{1'b0}}, a_next};
            mul_mplier <= b_reg;
            mul_cnt    <= '0;
        end else if (state == ST_MUL) begin
            mul_acc    <= mul_acc_next;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_cnt    <= mul_cnt + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Single-cycle ALU (SUB/AND/XOR) on the snapshot operands
    // ------------------------------------------------------------------
    assign sub_diff = {1'b0, exec_a} - {1'b0, exec_b};

    // Result, carry/borrow and signed-overflow for the one-cycle ops.
    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (exec_op)
            OP_SUB: begin
                alu_r = sub_diff[W-1:0];
                alu_c = sub_diff[W];
                alu_v = (exec_a[W-1] != exec_b[W-1]) &&
                        (sub_diff[W-1] != exec_a[W-1]);
            end
            OP_AND: begin
                alu_r = exec_a & exec_b;
            end
            OP_XOR: begin
                alu_r = exec_a ^ exec_b;
            end
            default: begin
                alu_r = '0;
            end
        endcase
    end

    // Select the completing op's result and C/V; MUL reports high-half
    // nonzero as both carry and overflow.
    always_comb begin
        fin_valid = 1'b0;
        fin_r     = '0;
        fin_c     = 1'b0;
        fin_v     = 1'b0;
        if (state == ST_EXEC) begin
            fin_valid = 1'b1;
            fin_r     = alu_r;
            fin_c     = alu_c;
            fin_v     = alu_v;
        end else if (mul_last) begin
            fin_valid = 1'b1;
            fin_r     = mul_acc_next[W-1:0];
            fin_c     = |mul_acc_next[2*W-1:W];
            fin_v     = |mul_acc_next[2*W-1:W];
        end
    end

    // ------------------------------------------------------------------
    // Result / flag hold and completion pulse
    // ------------------------------------------------------------------
    // Update result and {Z,C,V,N} only on completion; done pulses once.
    always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
        if (FPGA_reset) begin
            result <= '0;
            flags  <= 4'h0;
            done   <= 1'b0;
        end else begin
            done <= fin_valid;
            if (fin_valid) begin
                result <= fin_r;
                flags  <= {~|fin_r, fin_c, fin_v, fin_r[W-1]};
            end
        end
    end

    // ------------------------------------------------------------------
    // PWM: free-running counter compared against the live result
    // ------------------------------------------------------------------
    // Free-running PWM period counter.
    always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
        if (FPGA_reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + W'(1);
        end
    end

    assign pwm_out = (pwm_cnt < result);

endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Parametrised operand-capture / ALU-execute / result-hold controller: the next-generation core of the board controller. It takes operand A from the SPI slave's data strobe and operand B from debounced, active-low selector buttons. It executes MUL/SUB/AND/XOR on a debounced operation-button edge, using an iterative shift-add multiplier, and holds the result, the flags {Z,C,V,N} and a result-driven PWM for the LED, seven-segment and motor paths.

## Interface
- `W`, 4: data width of operands and result (≥2).
- `NB`, 4: number of operand-B selector buttons; requires clog2(NB) ≤ W.
- `FPGA_clk`  in  1  single clock, all state on rising edge.
- `FPGA_reset`  in  1  reset, asynchronous, active-high.
- `spi_data`  in  W  operand A candidate from SPI slave.
- `spi_valid`  in  1  one-cycle strobe; latches `spi_data` into A.
- `opb_btn_n`  in  NB  debounced operand-B buttons, active-low.
- `op_btn`  in  4  debounced op buttons, active-high: [0]=MUL, [1]=SUB, [2]=AND, [3]=XOR.
- `op_a`  out  W  current A register (display).
- `op_b`  out  W  current B register (display).
- `result`  out  W  last completed result.
- `flags`  out  4  {Z,C,V,N} of last completed op.
- `busy`  out  1  high while an op executes.
- `done`  out  1  one-cycle pulse when result/flags update.
- `pwm_out`  out  1  PWM with duty result/2^W.

## Operation
- A register: loads `spi_data` on every `spi_valid`, including while busy. A load while busy affects only the next op.
- B register: each cycle, if any `opb_btn_n` bit is 0, B = index of the lowest-indexed pressed bit, zero-extended to W. If no bit is pressed, B holds.
- Start: rising edge per `op_btn` bit, detected against a previous-sample register.
  - The previous-sample register resets to all-ones, so a button held through reset release never fires.
  - Simultaneous edges: priority MUL > SUB > AND > XOR; one op is started.
  - Edges while `busy`=1 are dropped, with no queueing.
- Snapshot: at start, A and B are copied into execution registers.
  - If `spi_valid` coincides with the start edge, the snapshot uses the new `spi_data`.
- FSM states: IDLE, EXEC, MUL.
  - IDLE → EXEC on a SUB/AND/XOR start.
  - IDLE → MUL on a MUL start.
  - EXEC → IDLE after 1 cycle.
  - MUL → IDLE after W cycles.
- MUL: shift-add, one multiplier bit per cycle, LSB first.
  - 2W-bit accumulator and a counter 0..W-1.
  - Product is unsigned 2W bits; `result` = low W bits; C = V = OR of the high W bits.
- SUB: R = (A − B) mod 2^W.
  - C = 1 on borrow (A < B unsigned).
  - V = (A[W-1] ≠ B[W-1]) & (R[W-1] ≠ A[W-1]).
- AND/XOR: R = A&B or A^B; C = V = 0.
- All ops: Z = (R == 0), N = R[W-1].
- `result`/`flags` change only on completion and hold between ops.
- PWM: free-running W-bit counter; `pwm_out` = (counter < `result`).
  - `result` = 0 gives constant low.
  - `result` = 2^W−1 gives high 2^W−1 of every 2^W cycles.
  - A new `result` takes effect immediately at the current counter value.

## Timing
- Reset values: all registers, `op_a`, `op_b`, `result`, `flags` (including Z) = 0; `busy` = 0, `done` = 0, `pwm_out` = 0; PWM counter = 0; FSM = IDLE.
- Reset mid-operation aborts the op: no `done` pulse; `result`/`flags` return to 0.
- Edge on cycle k (`op_btn` bit high at k, previous sample low):
  - `busy` = 1 from k+1.
  - SUB/AND/XOR: `result`/`flags` valid and `done` = 1 at k+2; `busy` = 0 at k+2.
  - MUL: `busy` high for cycles k+1..k+W; `result`/`flags` valid and `done` = 1 at k+W+1 (k+5 for W=4).
- `done` coincides with the first cycle of `busy` = 0. A new edge on that cycle is accepted.
- `op_a`/`op_b` register updates are visible 1 cycle after the `spi_valid`/button sample.

## Test plan
- Reset (W=4): all outputs 0 during and after reset; hold `op_btn`[1] high through reset release → no op starts, `done` never pulses.
- SUB: `spi_data`=3 with `spi_valid`, `opb_btn_n`=4'b1101 (B=1), SUB edge at k → `done` at k+2, `result`=2, `flags`=0000.
- SUB borrow: A=2, B=3 → `result`=0xF, {Z,C,V,N}=0101. Overflow case: A=8, B=1 → `result`=7, flags=0010.
- MUL: A=7, B=3 → `busy` for 4 cycles, `done` at k+5, `result`=5, flags=0110. A SUB edge at k+2 is dropped. `spi_valid` with 9 at k+2 → `op_a`=9, `result` still 5.
- XOR/AND and priority: A=3, B=3, XOR → `result`=0, flags=1000. Simultaneous AND+XOR edges with A=6, B=3 → AND runs, `result`=2.
- PWM and abort: `result`=8 → `pwm_out` high exactly 8 of every 16 cycles. Assert reset at k+2 of a MUL → `result`=0, `pwm_out`=0, no `done`.
